alu_board_ctrl: RTL and testbench
=================================

Name: alu_board_ctrl

Overview:
- Parametrised successor of the board-level switch/button/LED top: turns the raw switches and buttons into a sequential operand/opcode loader driving an ALU whose registered result is shown on the LEDs.
- Each button is synchronised, debounced and edge-detected. Button pulses latch the switch value into operand A, operand B or the opcode register.
- Sits directly under the FPGA pins and is the board top for the ALU practical.

Parameters:
- NB_DATA, 8, width of switches, operands, result and LEDs.
- NB_OP, 6, opcode width; the opcode is taken from i_sw[NB_OP-1:0]. Requires NB_OP <= NB_DATA.
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles before a button level is accepted (10 ms at 100 MHz). Must be >= 1.

Ports:
- clk  input  1  system clock; all state is rising-edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_sw  input  NB_DATA  raw switch bank, asynchronous to clk.
- i_button  input  3  raw buttons, asynchronous to clk: [0] load A, [1] load B, [2] load opcode.
- o_led  output  NB_DATA  registered ALU result.

Interface rule (already decided): one clock; reset is asynchronous and active-high; clock port is clk, reset port is i_reset.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All synchronisers, debounce counters, stable levels, edge registers, A, B, opcode and o_led go to 0.
  - A reset asserted mid-debounce discards the partial count.
- Synchronisation: i_sw and each i_button pass through a 2-flop synchroniser; only synchronised values are used.
- Debounce, per button:
  - Counter cnt and stable level lvl.
  - If sync != lvl, cnt increments. When cnt reaches DEBOUNCE_CYCLES-1 while sync != lvl, lvl <= sync and cnt <= 0.
  - If sync == lvl, cnt <= 0, so any bounce restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Edge detect: pulse = lvl & ~lvl_d. The pulse is exactly one cycle per accepted press; release produces no pulse.
- Loads, on pulse:
  - pulse[0]: A <= sw_sync.
  - pulse[1]: B <= sw_sync.
  - pulse[2]: OP <= sw_sync[NB_OP-1:0].
  - Simultaneous pulses all load in the same cycle from the same switch value.
- ALU, combinational from A, B, OP, NB_DATA-bit wraparound:
  - 100000 ADD: A+B.
  - 100010 SUB: A-B.
  - 100100 AND.
  - 100101 OR.
  - 100110 XOR.
  - 100111 NOR.
  - 000011 SRA: A>>>B, signed.
  - 000010 SRL: A>>B.
  - Any other opcode: 0.
  - Shifts with B >= NB_DATA: SRL gives 0; SRA gives all bits = A[NB_DATA-1].
- Result register: o_led <= alu_out every cycle. o_led reflects a load one cycle after the load edge.
- Latency from a clean raw press: 2 (sync) + DEBOUNCE_CYCLES (debounce) + 1 (edge/load) + 1 (result) cycles to o_led.
- Holding a button produces no repeat loads.
- Switches changing while no button is pressed have no effect on o_led.

Optional Feature:
- Macro ALU_BOARD_FLAGS_EN.
- Defined: adds port o_flags, output, 2 bits, registered alongside o_led and reset to 0.
  - [0] zero: result == 0.
  - [1] carry: ADD carry-out of the NB_DATA+1-bit sum; SUB borrow, i.e. A < B unsigned; 0 for all other opcodes.
- Undefined: no o_flags port, no flag logic; behaviour is otherwise identical.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset during operation: A=8'h12 loaded, then assert i_reset asynchronously between edges -> o_led=0 immediately, A/B/OP=0; after release, load OP=ADD -> o_led=8'h00.
- Basic ADD: i_sw=8'h05, press btn0; i_sw=8'h03, press btn1; i_sw=8'h20, press btn2 -> o_led=8'h08, exactly 8 cycles after the clean btn2 edge (2+4+1+1).
- Debounce rejection: btn0 toggled 0/1 every 2 cycles for 20 cycles with i_sw=8'hAA, then held low -> A unchanged, o_led unchanged. A clean press held 6 cycles -> exactly one load.
- Wraparound and shifts: A=8'hF0, B=8'h20, ADD -> 8'h10 (carry=1 with flags). SUB with A=8'h01, B=8'h02 -> 8'hFF (borrow=1). SRA A=8'h80, B=8'h09 -> 8'hFF. SRL same operands -> 8'h00.
- Simultaneous load: all three buttons pressed together with i_sw=8'h27 -> A=B=8'h27, OP=6'h27 (NOR) -> o_led=8'hD8.
- Invalid opcode: OP=6'h3F with A=8'h11 -> o_led=8'h00 (zero flag=1 with flags); holding btn2 for 100 cycles -> no further loads.

Source files
------------

// File: rtl/alu_board_ctrl.sv
// Board top for the ALU practical: debounced buttons load A/B/opcode from switches.
// Optional ALU_BOARD_FLAGS_EN adds registered zero/carry flags on o_flags.
module alu_board_ctrl #(
    parameter int NB_DATA         = 8,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic [2:0]         i_button,
`ifdef ALU_BOARD_FLAGS_EN
    output logic [1:0]         o_flags,
`endif
    output logic [NB_DATA-1:0] o_led
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    logic [1:0]         rst_ff;
    logic               rst;
    logic [NB_DATA-1:0] sw_meta;
    logic [NB_DATA-1:0] sw_sync;
    logic [2:0]         btn_meta;
    logic [2:0]         btn_sync;
    logic [CW-1:0]      cnt [3];
    logic [2:0]         lvl;
    logic [2:0]         lvl_d;
    logic [2:0]         pulse;
    logic [NB_DATA-1:0] reg_a;
    logic [NB_DATA-1:0] reg_b;
    logic [NB_OP-1:0]   reg_op;
    logic [NB_DATA-1:0] alu_out;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            rst_ff <= 2'b11;
        end else begin
            rst_ff <= {rst_ff[0], 1'b0};
        end
    end

    assign rst = rst_ff[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= i_sw;
            sw_sync  <= sw_meta;
            btn_meta <= i_button;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
            lvl   <= '0;
            lvl_d <= '0;
        end else begin
            lvl_d <= lvl;
            for (int i = 0; i < 3; i++) begin
                if (btn_sync[i] != lvl[i]) begin
                    if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        lvl[i] <= btn_sync[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign pulse = lvl & ~lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= '0;
        end else begin
            if (pulse[0]) reg_a  <= sw_sync;
            if (pulse[1]) reg_b  <= sw_sync;
            if (pulse[2]) reg_op <= sw_sync[NB_OP-1:0];
        end
    end

    // Oversized shift amounts saturate naturally: zero fill or sign fill.
    always_comb begin
        alu_out = '0;
        unique case (reg_op)
            OP_ADD:  alu_out = reg_a + reg_b;
            OP_SUB:  alu_out = reg_a - reg_b;
            OP_AND:  alu_out = reg_a & reg_b;
            OP_OR:   alu_out = reg_a | reg_b;
            OP_XOR:  alu_out = reg_a ^ reg_b;
            OP_NOR:  alu_out = ~(reg_a | reg_b);
            OP_SRA:  alu_out = $signed(reg_a) >>> reg_b;
            OP_SRL:  alu_out = reg_a >> reg_b;
            default: alu_out = '0;
        endcase
    end

`ifdef ALU_BOARD_FLAGS_EN
    logic [NB_DATA:0] sum;
    logic             carry;

    assign sum = {1'b0, reg_a} + {1'b0, reg_b};

    always_comb begin
        carry = 1'b0;
        if (reg_op == OP_ADD) begin
            carry = sum[NB_DATA];
        end else if (reg_op == OP_SUB) begin
            carry = reg_a < reg_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_flags <= '0;
        end else begin
            o_flags <= {carry, alu_out == '0};
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_led <= '0;
        end else begin
            o_led <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_board_ctrl.sv
// Directed bench for alu_board_ctrl with a short debounce window.
module tb_alu_board_ctrl;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_sw;
    logic [2:0] i_button;
    logic [7:0] o_led;
`ifdef ALU_BOARD_FLAGS_EN
    logic [1:0] o_flags;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses [3];
    int base;

    alu_board_ctrl #(
        .NB_DATA(8),
        .NB_OP(6),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .i_reset(i_reset),
        .i_sw(i_sw),
        .i_button(i_button),
`ifdef ALU_BOARD_FLAGS_EN
        .o_flags(o_flags),
`endif
        .o_led(o_led)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dut.pulse[i]) pulses[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [2:0] mask, input logic [7:0] sw,
                         input int hold);
        @(negedge clk);
        i_sw = sw;
        repeat (3) @(negedge clk);
        i_button = mask;
        repeat (hold) @(negedge clk);
        i_button = '0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        i_reset  = 1'b1;
        i_sw     = '0;
        i_button = '0;
        repeat (3) @(negedge clk);
        check("rst_led", o_led, 8'h00);
        check("rst_a", dut.reg_a, 8'h00);
        check("rst_b", dut.reg_b, 8'h00);
        check("rst_op", dut.reg_op, 6'h00);
        i_reset = 1'b0;
        repeat (4) @(negedge clk);

        press(3'b001, 8'h05, 6);
        press(3'b010, 8'h03, 6);
        check("add_pre", o_led, 8'h00);
        @(negedge clk);
        i_sw = 8'h20;
        repeat (3) @(negedge clk);
        i_button = 3'b100;
        repeat (7) @(negedge clk);
        check("lat_7", o_led, 8'h00);
        @(negedge clk);
        check("lat_8", o_led, 8'h08);
        i_button = '0;
        repeat (10) @(negedge clk);

        base = pulses[0];
        @(negedge clk);
        i_sw = 8'hAA;
        for (int k = 0; k < 10; k++) begin
            i_button = (k % 2 == 0) ? 3'b001 : 3'b000;
            repeat (2) @(negedge clk);
        end
        i_button = '0;
        repeat (10) @(negedge clk);
        check("bounce_led", o_led, 8'h08);
        check("bounce_a", dut.reg_a, 8'h05);
        check("bounce_pulses", pulses[0] - base, 0);

        base = pulses[0];
        press(3'b001, 8'h10, 6);
        check("clean_pulses", pulses[0] - base, 1);
        check("clean_led", o_led, 8'h13);

        press(3'b001, 8'hF0, 6);
        press(3'b010, 8'h20, 6);
        check("add_wrap", o_led, 8'h10);
`ifdef ALU_BOARD_FLAGS_EN
        check("add_flags", o_flags, 2'b10);
`endif

        press(3'b001, 8'h01, 6);
        press(3'b010, 8'h02, 6);
        press(3'b100, 8'h22, 6);
        check("sub_wrap", o_led, 8'hFF);
`ifdef ALU_BOARD_FLAGS_EN
        check("sub_flags", o_flags, 2'b10);
`endif

        press(3'b001, 8'h80, 6);
        press(3'b010, 8'h09, 6);
        press(3'b100, 8'h03, 6);
        check("sra_big", o_led, 8'hFF);
`ifdef ALU_BOARD_FLAGS_EN
        check("sra_flags", o_flags, 2'b00);
`endif
        press(3'b100, 8'h02, 6);
        check("srl_big", o_led, 8'h00);
`ifdef ALU_BOARD_FLAGS_EN
        check("srl_flags", o_flags, 2'b01);
`endif

        press(3'b111, 8'h27, 6);
        check("sim_led", o_led, 8'hD8);
        check("sim_a", dut.reg_a, 8'h27);
        check("sim_b", dut.reg_b, 8'h27);
        check("sim_op", dut.reg_op, 6'h27);

        press(3'b001, 8'h12, 6);
        check("pre_rst", o_led, 8'hC8);
        @(posedge clk);
        #2 i_reset = 1'b1;
        #1;
        check("mid_rst_led", o_led, 8'h00);
        check("mid_rst_a", dut.reg_a, 8'h00);
        check("mid_rst_b", dut.reg_b, 8'h00);
        check("mid_rst_op", dut.reg_op, 6'h00);
        @(negedge clk);
        i_reset = 1'b0;
        repeat (4) @(negedge clk);
        press(3'b100, 8'h20, 6);
        check("post_rst_add", o_led, 8'h00);
`ifdef ALU_BOARD_FLAGS_EN
        check("post_rst_flags", o_flags, 2'b01);
`endif

        press(3'b001, 8'h11, 6);
        check("add_11", o_led, 8'h11);
        base = pulses[2];
        @(negedge clk);
        i_sw = 8'h3F;
        repeat (3) @(negedge clk);
        i_button = 3'b100;
        repeat (20) @(negedge clk);
        i_sw = 8'h20;
        repeat (80) @(negedge clk);
        i_button = '0;
        repeat (10) @(negedge clk);
        check("inv_led", o_led, 8'h00);
        check("inv_op", dut.reg_op, 6'h3F);
        check("hold_pulses", pulses[2] - base, 1);
`ifdef ALU_BOARD_FLAGS_EN
        check("inv_flags", o_flags, 2'b01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
